// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-handling engine: FSM state encoding
// and default block geometry (16-byte blocks of eight 16-bit words).
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_OFFSET_BITS  = 3;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear, count enable and a
// terminal-count flag. Used once for issued requests and once for
// received words during a block fill.
module fill_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  // Terminal count is a pure decode of the register so it is valid the
  // same cycle the count reaches LIMIT.
  assign done = (count == LIMIT_V);

  // Count up while enabled, hold at LIMIT; clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-handling engine. On an accepted miss it issues one read per
// word of the missing block back-to-back, streams each returned word into
// the data array, and on the last word writes the tag array. The pipeline
// is stalled (fsm_busy) for the whole fill. rst is asynchronous, active-low.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS  = WORDS_PER_BLOCK,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     mem_grant,
  input  logic                     memory_data_valid,
  input  logic [DATA_W-1:0]        memory_data,
  output logic                     fsm_busy,
  output logic                     mem_read_req,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] word_offset,
  output logic                     write_tag_array,
  output logic [DATA_W-1:0]        fill_data
);

  localparam int OFF_W      = $clog2(WORDS);
  localparam int REQ_W      = OFF_W + 1;
  localparam int WORD_BYTES = DATA_W / 8;
  localparam int BLK_W      = $clog2(WORDS * WORD_BYTES);

  // Clears the byte-within-block bits of a missing address.
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLK_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_BYTES);

  fill_state_t         state;
  logic [ADDR_W-1:0]   base_addr;
  logic [REQ_W-1:0]    req_cnt;
  logic [OFF_W-1:0]    rcv_cnt;
  logic                req_done;
  logic                rcv_last;
  logic                in_fill;
  logic                accept;
  logic                last_word;

  assign in_fill   = (state == FILL);
  // A miss is only looked at while idle; a miss raised during a fill is
  // dropped and the cache re-raises it once the stall is released.
  assign accept    = (state == IDLE) && miss_detected && mem_grant;
  assign last_word = in_fill && memory_data_valid && rcv_last;

  // Requests issued: one per cycle in FILL until all words are requested.
  fill_counter #(
    .WIDTH (REQ_W),
    .LIMIT (WORDS)
  ) u_req_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (in_fill),
    .count  (req_cnt),
    .done   (req_done)
  );

  // Words received: independent of the request side because responses
  // start arriving while requests are still being issued.
  fill_counter #(
    .WIDTH (OFF_W),
    .LIMIT (WORDS - 1)
  ) u_rcv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (in_fill && memory_data_valid),
    .count  (rcv_cnt),
    .done   (rcv_last)
  );

  // Control FSM: latch the block-aligned base on acceptance, return to IDLE
  // the cycle after the final word (and its tag write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= FILL;
            base_addr <= miss_address & BLK_MASK;
          end
        end
        FILL: begin
          if (last_word) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_busy = in_fill;

  // Memory and array strobes decode from state and counters only; in IDLE
  // (and under reset) every output is held at zero.
  always_comb begin
    mem_read_req     = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    write_tag_array  = 1'b0;
    fill_data        = '0;
    if (in_fill) begin
      mem_read_req     = !req_done;
      // Word addresses stay inside the aligned block, so the add wraps
      // modulo 2^ADDR_W without carrying out of the block.
      memory_address   = req_done ? base_addr : base_addr + ADDR_W'(req_cnt) * STEP;
      write_data_array = memory_data_valid;
      word_offset      = rcv_cnt;
      write_tag_array  = last_word;
      fill_data        = memory_data;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a pipelined memory model answers
// whatever the DUT requests after a fixed latency, and a fill-level
// reference model predicts every output each cycle.
module tb_cache_fill_fsm;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_grant;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic        write_tag_array;
  logic [15:0] fill_data;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .mem_grant         (mem_grant),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_req      (mem_read_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .write_tag_array   (write_tag_array),
    .fill_data         (fill_data)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  int          lat = 4;
  int          cyc = 0;
  int          chk = 0;
  int          pass = 0;
  logic [15:0] seed;

  // Fill-level reference model: is a fill in flight, its block base, how
  // many cycles it has run, and how many words it has received.
  bit          m_active;
  logic [15:0] m_base;
  int          m_age;
  int          m_rcv;

  int          n_req, n_wr, n_tag, tag_cyc, n_bad_addr;
  logic [38:0] obs_v, exp_v;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ seed;
  endfunction

  task automatic clear_tally();
    n_req = 0; n_wr = 0; n_tag = 0; tag_cyc = -1; n_bad_addr = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, let the
  // combinational outputs settle, record observed and predicted outputs,
  // then advance the memory and reference models across the rising edge.
  task automatic tick(input logic mi, input logic [15:0] ma, input logic gr, input logic xv);
    logic        mv;
    logic [15:0] md;
    logic        e_req, e_wr, e_tag;
    logic [15:0] e_addr, e_data;
    logic [2:0]  e_off;
    @(negedge clk);
    miss_detected = mi;
    miss_address  = ma;
    mem_grant     = gr;
    mv = 1'b0;
    md = 16'($urandom);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mv = 1'b1;
      md = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    memory_data_valid = mv | xv;
    memory_data       = md;
    #1;
    e_req  = m_active && (m_age < WORDS);
    e_addr = !m_active ? 16'h0 : (m_age < WORDS ? m_base + 16'(2 * m_age) : m_base);
    e_wr   = m_active && memory_data_valid;
    e_off  = m_active ? 3'(m_rcv) : 3'd0;
    e_tag  = e_wr && (m_rcv == WORDS - 1);
    e_data = m_active ? memory_data : 16'h0;
    exp_v  = {m_active, e_req, e_addr, e_wr, e_off, e_tag, e_data};
    obs_v  = {fsm_busy, mem_read_req, memory_address, write_data_array, word_offset,
              write_tag_array, fill_data};
    if (mem_read_req) begin
      mq.push_back('{due: cyc + lat, addr: memory_address});
      n_req++;
      if ((memory_address & 16'hFFF0) != m_base) n_bad_addr++;
    end
    if (write_data_array) n_wr++;
    if (write_tag_array) begin
      n_tag++;
      tag_cyc = cyc;
    end
    if (m_active) begin
      if (memory_data_valid) begin
        if (m_rcv == WORDS - 1) m_active = 1'b0;
        m_rcv++;
      end
      m_age++;
    end else if (mi && gr) begin
      m_active = 1'b1;
      m_base   = {ma[15:4], 4'h0};
      m_age    = 0;
      m_rcv    = 0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      miss_detected     = 1'b1;
      miss_address      = 16'($urandom);
      mem_grant         = 1'b1;
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      #1;
      obs_v = {fsm_busy, mem_read_req, memory_address, write_data_array, word_offset,
               write_tag_array, fill_data};
      chk++;
      if (obs_v !== 39'h0) $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs_v);
      else pass++;
      cyc++;
    end
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b0; mem_grant = 1'b0; memory_data_valid = 1'b0;
    cyc++;
    m_active = 1'b0; m_base = 16'h0;
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    chk++;
    if (obs_v !== exp_v) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else pass++;
  endtask

  task automatic test_basic_fill();
    int c0;
    clear_tally();
    lat = 4;
    c0 = cyc;
    tick(1'b1, 16'h1236, 1'b1, 1'b0);
    chk++;
    if (obs_v !== exp_v) $display("FAIL basic_accept cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else pass++;
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL basic_fill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    chk++;
    if (obs_v !== exp_v) $display("FAIL basic_after cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else pass++;
    chk++;
    if (tag_cyc - c0 !== 12) $display("FAIL basic_tag_latency got=%0d exp=12", tag_cyc - c0);
    else pass++;
    chk++;
    if (n_req !== 8 || n_wr !== 8 || n_tag !== 1)
      $display("FAIL basic_counts got req=%0d wr=%0d tag=%0d exp 8/8/1", n_req, n_wr, n_tag);
    else pass++;
  endtask

  task automatic test_grant_gating();
    logic [15:0] a;
    clear_tally();
    a = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, a, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL gate_wait cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_req !== 0) $display("FAIL gate_no_req got=%0d exp=0", n_req);
    else pass++;
    tick(1'b1, a, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL gate_fill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_wr !== 8 || n_tag !== 1) $display("FAIL gate_counts got wr=%0d tag=%0d exp 8/1", n_wr, n_tag);
    else pass++;
  endtask

  task automatic test_addr_wrap();
    clear_tally();
    tick(1'b1, 16'hFFFA, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL wrap_fill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_bad_addr !== 0 || n_req !== 8)
      $display("FAIL wrap_addr got bad=%0d req=%0d exp 0/8", n_bad_addr, n_req);
    else pass++;
  endtask

  task automatic test_reset_mid_fill();
    clear_tally();
    tick(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 40 && n_wr < 3; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL abort_pre cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      miss_detected = 1'b1; mem_grant = 1'b1; memory_data_valid = 1'b1;
      miss_address = 16'($urandom); memory_data = 16'($urandom);
      #1;
      obs_v = {fsm_busy, mem_read_req, memory_address, write_data_array, word_offset,
               write_tag_array, fill_data};
      chk++;
      if (obs_v !== 39'h0) $display("FAIL abort_outputs cyc=%0d got=%h exp=0", cyc, obs_v);
      else pass++;
      cyc++;
    end
    m_active = 1'b0;
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b0; mem_grant = 1'b0; memory_data_valid = 1'b0;
    cyc++;
    chk++;
    if (n_tag !== 0) $display("FAIL abort_no_tag got=%0d exp=0", n_tag);
    else pass++;
    clear_tally();
    tick(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL abort_refill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_wr !== 8 || n_tag !== 1) $display("FAIL abort_refill_counts got wr=%0d tag=%0d exp 8/1", n_wr, n_tag);
    else pass++;
  endtask

  task automatic test_spurious();
    clear_tally();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      chk++;
      if (obs_v !== exp_v) $display("FAIL spur_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_wr !== 0) $display("FAIL spur_idle_writes got=%0d exp=0", n_wr);
    else pass++;
    tick(1'b1, 16'h4A5C, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b1, 16'($urandom), 1'b1, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL spur_fill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_wr !== 8 || n_tag !== 1 || n_bad_addr !== 0)
      $display("FAIL spur_counts got wr=%0d tag=%0d bad=%0d exp 8/1/0", n_wr, n_tag, n_bad_addr);
    else pass++;
  endtask

  task automatic test_back_to_back();
    clear_tally();
    tick(1'b1, 16'h2000, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL b2b_first cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    tick(1'b1, 16'h3C7E, 1'b1, 1'b0);
    chk++;
    if (obs_v !== exp_v) $display("FAIL b2b_accept cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else pass++;
    for (int i = 0; i < 40 && m_active; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      chk++;
      if (obs_v !== exp_v) $display("FAIL b2b_second cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else pass++;
    end
    chk++;
    if (n_wr !== 16 || n_tag !== 2) $display("FAIL b2b_counts got wr=%0d tag=%0d exp 16/2", n_wr, n_tag);
    else pass++;
  endtask

  task automatic test_random();
    logic [15:0] a;
    int          gap;
    clear_tally();
    for (int f = 0; f < 20; f++) begin
      lat = $urandom_range(1, 8);
      a   = 16'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        chk++;
        if (obs_v !== exp_v) $display("FAIL rand_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
        else pass++;
      end
      tick(1'b1, a, 1'b1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 60 && m_active; i++) begin
        tick(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        chk++;
        if (obs_v !== exp_v) $display("FAIL rand_fill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
        else pass++;
      end
      chk++;
      if (m_active) $display("FAIL rand_timeout fill=%0d got=busy exp=idle", f);
      else pass++;
    end
    chk++;
    if (n_wr !== 160 || n_tag !== 20) $display("FAIL rand_counts got wr=%0d tag=%0d exp 160/20", n_wr, n_tag);
    else pass++;
  endtask

  initial begin
    seed = 16'($urandom);
    m_active = 1'b0; m_base = 16'h0; m_age = 0; m_rcv = 0;
    clear_tally();
    miss_detected = 1'b0; miss_address = 16'h0; mem_grant = 1'b0;
    memory_data_valid = 1'b0; memory_data = 16'h0;
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_basic_fill();
    test_grant_gating();
    test_addr_wrap();
    test_reset_mid_fill();
    test_spurious();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine instantiated inside each cache (iCache, dCache). It sits directly upstream of the memory arbiter and memory4c.
- On a cache miss it fetches one 16-byte block (8 x 16-bit words) from the pipelined memory.
- Each returned word is streamed into the cache data array. On the last word it writes the tag array and releases the pipeline stall.

Parameters:
- WORDS, 8, words per cache block (power of two).
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_W  byte address that missed.
- mem_grant  in  1  arbiter permits this cache to start a fill.
- memory_data_valid  in  1  memory returns a word this cycle (already routed by the arbiter).
- memory_data  in  DATA_W  returned word.
- fsm_busy  out  1  fill in progress; stalls the pipeline.
- mem_read_req  out  1  read request to memory.
- memory_address  out  ADDR_W  address of the current request.
- write_data_array  out  1  write memory_data into the data array at word_offset.
- word_offset  out  log2(WORDS)  word index within the block being written.
- write_tag_array  out  1  one-cycle pulse; write the tag and set valid for the block.
- fill_data  out  DATA_W  equals memory_data, passed through to the data array.

Behaviour:
- States: IDLE, FILL. State is 1 flop, encoding taken from cache_pkg.
- Counters:
  - req_cnt: 4 bits, counts requests issued.
  - rcv_cnt: 3 bits, counts words received.
- Registers: base_addr (ADDR_W).
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - req_cnt, rcv_cnt and base_addr clear to 0.
  - All outputs are 0.
- IDLE:
  - When miss_detected=1 and mem_grant=1: latch base_addr = miss_address with bits [3:0] cleared, clear both counters, go to FILL next cycle.
  - miss_detected=1 with mem_grant=0 stays in IDLE. The miss is re-evaluated every cycle.
  - memory_data_valid is ignored; no array writes occur.
- FILL, requests:
  - mem_read_req = (req_cnt < WORDS).
  - memory_address = base_addr + 2*req_cnt[2:0], with modulo-2^ADDR_W arithmetic; base 0xFFF0 yields 0xFFF0..0xFFFE.
  - req_cnt increments each cycle while below WORDS, then saturates at WORDS.
  - When mem_read_req=0, memory_address = base_addr.
- FILL, responses:
  - write_data_array = memory_data_valid.
  - word_offset = rcv_cnt.
  - fill_data = memory_data.
  - rcv_cnt increments on each valid.
- FILL, completion:
  - When memory_data_valid=1 and rcv_cnt==WORDS-1: write_tag_array=1 in that same cycle, then go to IDLE next cycle.
- fsm_busy = (state==FILL), combinational from the state flop.
  - It rises the cycle after the miss is accepted.
  - It falls the cycle after the tag write.
- Combinational output rules:
  - mem_read_req, memory_address and the write strobes are combinational from state and counters.
  - No output is driven by miss_detected directly.
- Timing:
  - Requests are issued back-to-back for 8 cycles.
  - Total fill latency is 1 + L + 7 cycles from acceptance to tag write, with memory latency L (memory4c: L=4).
- Boundary cases:
  - miss_detected while busy is ignored. The cache re-raises it after refill if still missing.
  - Extra memory_data_valid after completion (in IDLE) is ignored.
  - memory_data_valid may arrive while requests are still issuing; the request and response counters are independent.
  - rst asserted mid-fill aborts immediately. No tag write occurs, so the partially written block stays invalid.
  - A miss can be accepted in the cycle immediately after a return to IDLE.

Decomposition:
- cache_pkg holds: state encoding (IDLE, FILL), WORDS_PER_BLOCK=8, BLOCK_OFFSET_BITS=4, WORD_OFFSET_BITS=3.
- One natural sub-module: fill_counter. It is a saturating up-counter with clear, enable and terminal-count flag, instantiated twice (requests, responses).

Test Plan:
- Basic fill:
  - Stimulus: rst released; miss_detected=1, miss_address=0x1236, mem_grant=1 at cycle 0; memory model L=4.
  - Response: busy high from cycle 1; requests to 0x1230..0x123E in cycles 1-8; write_data_array at cycles 5-12 with word_offset 0..7; write_tag_array only at cycle 12; busy low at cycle 13.
- Grant gating:
  - Stimulus: miss_detected=1 with mem_grant=0 for 5 cycles, then mem_grant=1.
  - Response: no mem_read_req and busy=0 during the 5 cycles; fill starts the cycle after grant.
- Address wrap:
  - Stimulus: miss_address=0xFFFA.
  - Response: requests 0xFFF0, 0xFFF2 … 0xFFFE; no address reaches 0x0000.
- Reset mid-fill:
  - Stimulus: rst=0 after the 3rd returned word.
  - Response: all outputs 0 immediately; write_tag_array never pulses; the next miss restarts at word_offset 0.
- Spurious and overlapping events:
  - Stimulus: memory_data_valid pulses in IDLE; miss_detected held high during FILL with a different address.
  - Response: no array writes in IDLE; base_addr unchanged during FILL; exactly 8 data writes and 1 tag write.
- Back-to-back misses:
  - Stimulus: second miss asserted in the first IDLE cycle after a completed fill.
  - Response: new fill accepted that cycle; busy high again the next cycle; the second block fills correctly.
